// File: rtl/event_stream_merger_if.sv
// Event bus between per-channel producers, the merger and the downstream scheduler.
// Per-channel fields are packed [ch][bits], bit-identical to the flat c*W +: W layout.
interface event_stream_merger_if #(
  parameter int N_CH       = 4,
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 16
) ();
  localparam int CH_W = $clog2(N_CH);

  logic [N_CH-1:0]                 in_event_valid;
  logic [N_CH-1:0][DATA_WIDTH-1:0] in_event_value;
  logic [N_CH-1:0][ADDR_WIDTH-1:0] in_event_addr;
  logic [N_CH-1:0]                 out_event_req;
  logic                            event_req;
  logic                            out_event_valid;
  logic [DATA_WIDTH-1:0]           out_event_value;
  logic [ADDR_WIDTH-1:0]           out_event_addr;
  logic [CH_W-1:0]                 out_event_ch;

  // slave: the merger itself; master: producers plus downstream scheduler
  modport slave (
    input  in_event_valid, in_event_value, in_event_addr, event_req,
    output out_event_req, out_event_valid, out_event_value, out_event_addr, out_event_ch
  );
  modport master (
    output in_event_valid, in_event_value, in_event_addr, event_req,
    input  out_event_req, out_event_valid, out_event_value, out_event_addr, out_event_ch
  );
endinterface

// File: rtl/event_stream_merger.sv
// Merges N_CH sparse event streams through per-channel FIFOs and a round-robin
// arbiter into one scheduler stream with a 3-cycle IDLE/ISSUE/GAP handshake.
module esm_ch_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         en,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         req,
  output logic         overflow
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW:0]             count;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic                    full, do_push, do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
      if (push && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk)
    if (rst_n && !flush && do_push) mem[wr_ptr] <= din;

  // Two free slots so a strobe already in flight when req falls still fits.
  always_ff @(posedge clk) begin
    if (!rst_n) req <= 1'b0;
    else        req <= en && (count <= (PW+1)'(DEPTH-2));
  end
endmodule

module event_stream_merger #(
  parameter int N_CH       = 4,
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH-1:0]        ch_enable,
  input  logic                   flush,
  event_stream_merger_if.slave   bus,
  output logic [N_CH-1:0]        overflow,
  output logic [31:0]            event_count
);
  localparam int CH_W = $clog2(N_CH);
  localparam int EW   = DATA_WIDTH + ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
  state_t state, state_nxt;

  logic [N_CH-1:0][EW-1:0] head;
  logic [N_CH-1:0]         empty, pop, elig, req;
  logic [CH_W-1:0]         rr_ptr, gnt_idx;
  logic                    gnt_found, load;
  int                      idx;

  generate
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
      esm_ch_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk, .rst_n, .flush,
        .en       (ch_enable[c]),
        .push     (bus.in_event_valid[c]),
        .din      ({bus.in_event_value[c], bus.in_event_addr[c]}),
        .pop      (pop[c]),
        .dout     (head[c]),
        .empty    (empty[c]),
        .req      (req[c]),
        .overflow (overflow[c])
      );
    end
  endgenerate

  assign bus.out_event_req = req;
  assign elig = ch_enable & ~empty;

  // First eligible channel at or after rr_ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int i = 0; i < N_CH; i++) begin
      idx = (int'(rr_ptr) + i) % N_CH;
      if (!gnt_found && elig[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = CH_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = ISSUE;
      ISSUE:   state_nxt = GAP;
      default: state_nxt = IDLE;
    endcase
  end

  // A flush in IDLE wins over a grant so nothing is popped from a clearing FIFO.
  always_comb begin
    load                = (state == IDLE) && bus.event_req && gnt_found && !flush;
    pop                 = load ? (N_CH'(1) << gnt_idx) : '0;
    bus.out_event_valid = (state == ISSUE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_event_value <= '0;
      bus.out_event_addr  <= '0;
      bus.out_event_ch    <= '0;
      rr_ptr              <= '0;
      event_count         <= '0;
    end else begin
      if (load) begin
        {bus.out_event_value, bus.out_event_addr} <= head[gnt_idx];
        bus.out_event_ch <= gnt_idx;
      end
      if (state == ISSUE) begin
        event_count <= event_count + 32'd1;
        rr_ptr <= (bus.out_event_ch == CH_W'(N_CH-1)) ? '0 : bus.out_event_ch + 1'b1;
      end
    end
  end
endmodule
